// File: rtl/mac_tx_arbiter_if.sv
// mac_tx_arbiter_if: UDP/TCP request ports and 32-bit AXIS master of the MAC transmit arbiter.
interface mac_tx_arbiter_if;
  logic         udp_valid;
  logic         udp_ready;
  logic [511:0] udp_data;
  logic [15:0]  udp_len;
  logic         tcp_valid;
  logic         tcp_ready;
  logic [511:0] tcp_data;
  logic [15:0]  tcp_len;
  logic         m_tvalid;
  logic         m_tready;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tkeep;
  logic [3:0]   m_tstrb;
  logic         m_tlast;
  logic [3:0]   m_tid;
  logic         busy;
  logic [15:0]  pkt_count;
  modport slave (
    input  udp_valid, udp_data, udp_len, tcp_valid, tcp_data, tcp_len, m_tready,
    output udp_ready, tcp_ready, m_tvalid, m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, busy, pkt_count
  );
  modport master (
    output udp_valid, udp_data, udp_len, tcp_valid, tcp_data, tcp_len, m_tready,
    input  udp_ready, tcp_ready, m_tvalid, m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, busy, pkt_count
  );
endinterface

// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: packet-level round-robin between UDP and TCP, serializing a 512-bit payload into 32-bit AXIS beats.
module mac_tx_arbiter (
  input  logic             clock,
  input  logic             reset,
  mac_tx_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t       state_q;
  logic         ptr_q, tid_q, valid_q;
  logic [511:0] data_q;
  logic [3:0]   idx_q, last_q;
  logic [1:0]   rem_q;
  logic [15:0]  pkt_q;
  logic         pick_tcp, accept, fire, at_last;
  logic [15:0]  len_d;
  logic [6:0]   clamp_d;
  always_comb begin
    pick_tcp = bus.tcp_valid && (!bus.udp_valid || ptr_q);
    accept   = state_q == IDLE && (bus.udp_valid || bus.tcp_valid);
    len_d    = pick_tcp ? bus.tcp_len : bus.udp_len;
    clamp_d  = len_d > 16'd64 ? 7'd64 : len_d[6:0];
    at_last  = idx_q == last_q;
    fire     = valid_q && bus.m_tready;
  end
  assign bus.udp_ready = accept && !pick_tcp;
  assign bus.tcp_ready = accept && pick_tcp;
  assign bus.m_tvalid  = valid_q;
  // Payload shifts down one beat per handshake, so the current beat is always the low word.
  assign bus.m_tdata   = data_q[31:0];
  assign bus.m_tkeep   = !valid_q ? 4'h0 : !at_last || rem_q == 2'd0 ? 4'hF :
                         rem_q == 2'd1 ? 4'h1 : rem_q == 2'd2 ? 4'h3 : 4'h7;
  assign bus.m_tstrb   = bus.m_tkeep;
  assign bus.m_tlast   = valid_q && at_last;
  assign bus.m_tid     = {3'b000, tid_q};
  assign bus.busy      = state_q == SEND;
  assign bus.pkt_count = pkt_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      tid_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      rem_q   <= '0;
      pkt_q   <= '0;
    end else if (state_q == IDLE) begin
      if (accept && clamp_d == 7'd0) ptr_q <= !ptr_q;
      else if (accept) begin
        state_q <= SEND;
        valid_q <= 1'b1;
        data_q  <= pick_tcp ? bus.tcp_data : bus.udp_data;
        tid_q   <= pick_tcp;
        idx_q   <= '0;
        last_q  <= 4'((clamp_d - 7'd1) >> 2);
        rem_q   <= clamp_d[1:0];
      end
    end else if (fire) begin
      if (at_last) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        pkt_q   <= pkt_q + 16'd1;
        ptr_q   <= !tid_q;
      end else begin
        idx_q  <= idx_q + 4'd1;
        data_q <= data_q >> 32;
      end
    end
  end
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: scenario tasks plus randomized traffic against a packet-level reference model.
module tb_mac_tx_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  mac_tx_arbiter_if bus();
  mac_tx_arbiter dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0, errors = 0;
  bit ptr_m = 1'b0;
  logic [15:0] pkt_m = '0;
  logic [31:0] g_data[$];
  logic [3:0]  g_keep[$];
  logic        g_last[$];
  logic [3:0]  g_tid[$];
  int win, ready_pulses;
  bit lat_ok;
  logic [511:0] ramp;

  function automatic int clampl(input logic [15:0] len);
    return len > 64 ? 64 : int'(len);
  endfunction
  function automatic int exp_beats(input logic [15:0] len);
    return (clampl(len) + 3) / 4;
  endfunction
  function automatic logic [31:0] exp_data(input logic [511:0] d, input int k);
    return d[32*k +: 32];
  endfunction
  function automatic logic [3:0] exp_keep(input logic [15:0] len, input int k);
    int l = clampl(len);
    return (k == exp_beats(len) - 1 && l % 4 != 0) ? 4'((1 << (l % 4)) - 1) : 4'hF;
  endfunction
  function automatic int exp_win(input bit uv, input bit tv);
    return (uv && tv) ? int'(ptr_m) : (tv ? 1 : 0);
  endfunction
  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_req(input bit uv, input bit tv, input logic [511:0] ud, input logic [511:0] td,
                        input logic [15:0] ul, input logic [15:0] tl, input int stall_pct);
    int n, budget;
    g_data.delete(); g_keep.delete(); g_last.delete(); g_tid.delete();
    win = -1; ready_pulses = 0; lat_ok = 1'b0;
    @(negedge clock);
    bus.udp_valid = uv; bus.udp_data = ud; bus.udp_len = ul;
    bus.tcp_valid = tv; bus.tcp_data = td; bus.tcp_len = tl;
    bus.m_tready = 1'b1;
    for (int c = 0; c < 20 && win < 0; c++) begin
      #1;
      if (bus.udp_ready) begin win = 0; ready_pulses++; end
      if (bus.tcp_ready) begin win = 1; ready_pulses++; end
      @(negedge clock);
    end
    bus.udp_valid = 1'b0; bus.tcp_valid = 1'b0;
    if (win < 0) return;
    n = exp_beats(win ? tl : ul);
    #1 lat_ok = bus.m_tvalid;
    if (bus.udp_ready || bus.tcp_ready) ready_pulses++;
    budget = n == 0 ? 4 : 400;
    for (int c = 0; c < budget && (g_last.size() == 0 || !g_last[$]); c++) begin
      if (c > 0) @(negedge clock);
      bus.m_tready = $urandom_range(99) >= stall_pct;
      #1;
      if (bus.m_tvalid && bus.m_tready) begin
        g_data.push_back(bus.m_tdata); g_keep.push_back(bus.m_tkeep);
        g_last.push_back(bus.m_tlast); g_tid.push_back(bus.m_tid);
      end
    end
    @(negedge clock);
    bus.m_tready = 1'b1;
    if (n == 0) ptr_m = !ptr_m;
    else begin ptr_m = !win[0]; pkt_m++; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    checks++; if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", bus.m_tvalid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt got %0d want 0", bus.pkt_count); end
    checks++;
    if ({bus.m_tkeep, bus.m_tstrb, bus.m_tlast, bus.m_tid, bus.m_tdata} !== '0) begin
      errors++; $display("FAIL reset_axis got keep=%h last=%b tid=%h data=%h want 0", bus.m_tkeep, bus.m_tlast, bus.m_tid, bus.m_tdata);
    end
    checks++; if (bus.udp_ready !== 1'b0 || bus.tcp_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b want 00", bus.udp_ready, bus.tcp_ready); end
    reset = 1'b0;
    ptr_m = 1'b0; pkt_m = '0;
  endtask

  task automatic test_udp_single();
    logic [31:0] want[3] = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
    do_req(1, 0, ramp, '0, 16'd12, 16'd0, 0);
    checks++; if (win !== 0 || ready_pulses !== 1) begin errors++; $display("FAIL udp_grant got win=%0d pulses=%0d want 0/1", win, ready_pulses); end
    checks++; if (lat_ok !== 1'b1) begin errors++; $display("FAIL udp_latency got tvalid=%b want 1", lat_ok); end
    checks++; if (g_data.size() !== 3) begin errors++; $display("FAIL udp_beats got %0d want 3", g_data.size()); end
    else for (int k = 0; k < 3; k++) begin
      checks++;
      if (g_data[k] !== want[k] || g_keep[k] !== 4'hF || g_last[k] !== (k == 2) || g_tid[k] !== 4'd0) begin
        errors++; $display("FAIL udp_beat%0d got %h/%h/%b/%h want %h/f/%b/0", k, g_data[k], g_keep[k], g_last[k], g_tid[k], want[k], k == 2);
      end
    end
    checks++; if (bus.pkt_count !== 16'd1) begin errors++; $display("FAIL udp_pkt got %0d want 1", bus.pkt_count); end
  endtask

  task automatic test_tcp_short();
    logic [511:0] d = rnd512();
    do_req(0, 1, '0, d, 16'd0, 16'd5, 0);
    checks++; if (win !== 1) begin errors++; $display("FAIL tcp_grant got %0d want 1", win); end
    checks++; if (g_data.size() !== 2) begin errors++; $display("FAIL tcp_beats got %0d want 2", g_data.size()); end
    else begin
      checks++;
      if (g_data[1] !== d[63:32] || g_keep[1] !== 4'h1 || g_last[1] !== 1'b1 || g_tid[1] !== 4'd1 || g_last[0] !== 1'b0) begin
        errors++; $display("FAIL tcp_last got %h/%h/%b/%h want %h/1/1/1", g_data[1], g_keep[1], g_last[1], g_tid[1], d[63:32]);
      end
    end
  endtask

  task automatic test_alternate();
    logic [511:0] ud = rnd512(), td = rnd512();
    int grants = 0, cur = -1;
    bit prev_v = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      if (c == 0) begin
        bus.udp_valid = 1; bus.udp_data = ud; bus.udp_len = 16'd4;
        bus.tcp_valid = 1; bus.tcp_data = td; bus.tcp_len = 16'd4;
      end
      #1;
      if (bus.udp_ready || bus.tcp_ready) begin
        cur = bus.tcp_ready ? 1 : 0;
        grants++; checks++;
        if (cur !== int'(ptr_m) || (bus.udp_ready && bus.tcp_ready)) begin
          errors++; $display("FAIL alt_grant%0d got %b%b want side %0d", grants, bus.udp_ready, bus.tcp_ready, ptr_m);
        end
        ptr_m = !cur[0]; pkt_m++;
      end
      if (bus.m_tvalid) begin
        checks++;
        if (prev_v || bus.m_tkeep !== 4'hF || bus.m_tlast !== 1'b1 || bus.m_tid !== 4'(cur) ||
            bus.m_tdata !== (cur ? td[31:0] : ud[31:0])) begin
          errors++; $display("FAIL alt_beat got prev=%b keep=%h last=%b tid=%h data=%h want 0/f/1/%0d", prev_v, bus.m_tkeep, bus.m_tlast, bus.m_tid, bus.m_tdata, cur);
        end
      end
      prev_v = bus.m_tvalid;
    end
    @(negedge clock);
    bus.udp_valid = 0; bus.tcp_valid = 0;
    checks++; if (grants !== 8) begin errors++; $display("FAIL alt_count got %0d want 8", grants); end
    #1;
    checks++; if (bus.pkt_count !== pkt_m) begin errors++; $display("FAIL alt_pkt got %0d want %0d", bus.pkt_count, pkt_m); end
  endtask

  task automatic test_backpressure();
    logic [511:0] d = rnd512();
    @(negedge clock);
    bus.udp_valid = 1; bus.udp_data = d; bus.udp_len = 16'd8; bus.tcp_valid = 0; bus.m_tready = 1;
    #1;
    checks++; if (bus.udp_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got %b want 1", bus.udp_ready); end
    @(negedge clock);
    bus.udp_valid = 0; bus.tcp_valid = 1; bus.tcp_data = rnd512(); bus.tcp_len = 16'd4;
    #1;
    checks++; if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== d[31:0] || bus.m_tlast !== 1'b0 || bus.tcp_ready !== 1'b0) begin
      errors++; $display("FAIL bp_beat0 got v=%b data=%h last=%b tr=%b want 1/%h/0/0", bus.m_tvalid, bus.m_tdata, bus.m_tlast, bus.tcp_ready, d[31:0]);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      bus.m_tready = c == 3;
      #1;
      checks++;
      if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== d[63:32] || bus.m_tkeep !== 4'hF || bus.m_tlast !== 1'b1 || bus.tcp_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got v=%b data=%h keep=%h last=%b tr=%b want 1/%h/f/1/0", c, bus.m_tvalid, bus.m_tdata, bus.m_tkeep, bus.m_tlast, bus.tcp_ready, d[63:32]);
      end
    end
    @(negedge clock);
    bus.tcp_valid = 0;
    ptr_m = 1'b1; pkt_m++;
    #1;
    checks++; if (bus.m_tvalid !== 1'b0 || bus.busy !== 1'b0 || bus.pkt_count !== pkt_m) begin
      errors++; $display("FAIL bp_end got v=%b busy=%b pkt=%0d want 0/0/%0d", bus.m_tvalid, bus.busy, bus.pkt_count, pkt_m);
    end
  endtask

  task automatic test_boundary();
    logic [511:0] d = rnd512();
    logic [31:0] q100[$];
    logic [15:0] pkt0 = pkt_m;
    int ew = exp_win(1, 1);
    do_req(1, 1, d, d, 16'd0, 16'd0, 0);
    checks++; if (win !== ew || g_data.size() !== 0 || bus.pkt_count !== pkt0) begin
      errors++; $display("FAIL zero_len got win=%0d beats=%0d pkt=%0d want %0d/0/%0d", win, g_data.size(), bus.pkt_count, ew, pkt0);
    end
    ew = exp_win(1, 1);
    do_req(1, 1, d, d, 16'd4, 16'd4, 0);
    checks++; if (win !== ew || ew === 1 - win) begin errors++; $display("FAIL zero_flip got win=%0d want %0d", win, ew); end
    do_req(1, 0, d, '0, 16'd100, 16'd0, 20);
    checks++; if (g_data.size() !== 16) begin errors++; $display("FAIL len100_beats got %0d want 16", g_data.size()); end
    else for (int k = 0; k < 16; k++) begin
      checks++;
      if (g_data[k] !== exp_data(d, k) || g_keep[k] !== 4'hF || g_last[k] !== (k == 15)) begin
        errors++; $display("FAIL len100_beat%0d got %h/%h/%b want %h/f/%b", k, g_data[k], g_keep[k], g_last[k], exp_data(d, k), k == 15);
      end
    end
    q100 = g_data;
    do_req(1, 0, d, '0, 16'd64, 16'd0, 0);
    checks++; if (g_data !== q100 || g_keep.size() !== 16 || !g_last[15]) begin
      errors++; $display("FAIL len64_vs_100 got beats=%0d want identical 16 beats", g_data.size());
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    bus.udp_valid = 1; bus.udp_data = rnd512(); bus.udp_len = 16'd64; bus.m_tready = 1;
    @(negedge clock);
    bus.udp_valid = 0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.m_tvalid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got busy=%b v=%b want 1/1", bus.busy, bus.m_tvalid); end
    @(negedge clock);
    #1;
    checks++; if (bus.m_tvalid !== 1'b0 || bus.busy !== 1'b0 || bus.pkt_count !== 16'd0 || bus.m_tlast !== 1'b0) begin
      errors++; $display("FAIL rst_mid got v=%b busy=%b pkt=%0d last=%b want 0/0/0/0", bus.m_tvalid, bus.busy, bus.pkt_count, bus.m_tlast);
    end
    reset = 1'b0;
    ptr_m = 1'b0; pkt_m = '0;
    do_req(1, 1, rnd512(), rnd512(), 16'd4, 16'd4, 0);
    checks++; if (win !== 0) begin errors++; $display("FAIL rst_mid_ptr got win=%0d want 0", win); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      bit uv = $urandom_range(1), tv;
      logic [511:0] ud = rnd512(), td = rnd512();
      logic [15:0] ul = 16'($urandom_range(1, 120)), tl = 16'($urandom_range(1, 120));
      int ew, n;
      tv = uv ? 1'($urandom_range(1)) : 1'b1;
      ew = exp_win(uv, tv);
      n = exp_beats(ew ? tl : ul);
      do_req(uv, tv, ud, td, ul, tl, 30);
      checks++; if (win !== ew || ready_pulses !== 1) begin errors++; $display("FAIL rnd%0d_grant got %0d/%0d want %0d/1", t, win, ready_pulses, ew); end
      checks++; if (g_data.size() !== n) begin errors++; $display("FAIL rnd%0d_beats got %0d want %0d", t, g_data.size(), n); end
      else for (int k = 0; k < n; k++) begin
        checks++;
        if (g_data[k] !== exp_data(ew ? td : ud, k) || g_keep[k] !== exp_keep(ew ? tl : ul, k) ||
            g_last[k] !== (k == n - 1) || g_tid[k] !== 4'(ew)) begin
          errors++; $display("FAIL rnd%0d_beat%0d got %h/%h/%b/%h want %h/%h/%b/%0d", t, k, g_data[k], g_keep[k], g_last[k], g_tid[k],
                             exp_data(ew ? td : ud, k), exp_keep(ew ? tl : ul, k), k == n - 1, ew);
        end
      end
      checks++; if (bus.pkt_count !== pkt_m) begin errors++; $display("FAIL rnd%0d_pkt got %0d want %0d", t, bus.pkt_count, pkt_m); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ramp[8*i +: 8] = 8'(i);
    bus.udp_valid = 0; bus.udp_data = '0; bus.udp_len = '0;
    bus.tcp_valid = 0; bus.tcp_data = '0; bus.tcp_len = '0;
    bus.m_tready = 1;
    test_reset();
    test_udp_single();
    test_tcp_short();
    test_alternate();
    test_backpressure();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
